// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the alu_arbiter slice.
//   arb_state_e       - arbiter FSM states
//   WIDTH_DEF/SEL_W_DEF - default operand and select widths
//   PORT0/PORT1       - port index encodings used for owner/last/win
package alu_arb_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned SEL_W_DEF = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// alu: combinational 16-operation ALU shared through alu_arbiter.
//   a, b : operands    sel : operation    y : result (WIDTH bits, no carry out)
//   0 add  1 sub  2 and  3 or  4 xor  5 nor  6 shl  7 shr  8 sra
//   9 slt(signed)  10 sltu  11 pass a  12 pass b  13 not a  14 inc a  15 dec a
module alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    y = '0;
    case (sel)
      'd0:  y = a + b;
      'd1:  y = a - b;
      'd2:  y = a & b;
      'd3:  y = a | b;
      'd4:  y = a ^ b;
      'd5:  y = ~(a | b);
      'd6:  y = a << sh;
      'd7:  y = a >> sh;
      'd8:  y = WIDTH'($signed(a) >>> sh);
      'd9:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      'd10: y = {{(WIDTH-1){1'b0}}, (a < b)};
      'd11: y = a;
      'd12: y = b;
      'd13: y = ~a;
      'd14: y = a + 1'b1;
      'd15: y = a - 1'b1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational 2-way request picker.
//   v0, v1 : request valids for port 0 / port 1
//   last   : port granted most recently
//   en     : picking allowed this cycle
//   win    : chosen port index (meaningful only when any=1)
//   any    : a grant is issued this cycle
// Macro ALU_ARB_RR_EN: defined -> round-robin (both valid: !last wins);
// undefined -> fixed priority, port 0 first.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic last,
  input  logic en,
  output logic win,
  output logic any
);

`ifdef ALU_ARB_RR_EN
  always_comb begin
    any = en & (v0 | v1);
    win = PORT0;
    if (v0 && v1) begin
      win = ~last;
    end else if (v1) begin
      win = PORT1;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    any = en & (v0 | v1);
    win = v0 ? PORT0 : PORT1;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, rst                 - clock, synchronous active-high reset
//   reqN_valid/ready         - request handshake, port N (0: execute, 1: aux)
//   reqN_a, reqN_b, reqN_sel - request operands and ALU operation
//   rspN_valid/ready         - response handshake, port N
//   rsp_data                 - held ALU result, qualified by rspN_valid
//   alu_a, alu_b, alu_sel    - registered operands/select driven to the ALU
//   alu_out                  - ALU combinational result
// Macro ALU_ARB_RR_EN selects round-robin arbitration (default: port 0 priority).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out
);

  arb_state_e state, state_nxt;
  logic       owner;
  logic       last;
  logic       can_accept;
  logic       owner_rsp_ready;
  logic       win;
  logic       accept;

  alu_arb_pick u_pick (
    .v0   (req0_valid),
    .v1   (req1_valid),
    .last (last),
    .en   (can_accept),
    .win  (win),
    .any  (accept)
  );

  always_comb begin
    owner_rsp_ready = (owner == PORT1) ? rsp1_ready : rsp0_ready;
    // Grants are blocked while rst is high so no request is consumed by a
    // cycle that reset is about to discard.
    can_accept = ~rst & ((state == ARB_IDLE) ||
                         ((state == ARB_RESP) && owner_rsp_ready));
    req0_ready = accept & (win == PORT0);
    req1_ready = accept & (win == PORT1);
    rsp0_valid = (state == ARB_RESP) && (owner == PORT0);
    rsp1_valid = (state == ARB_RESP) && (owner == PORT1);

    state_nxt = state;
    case (state)
      ARB_IDLE: if (accept) state_nxt = ARB_EXEC;
      ARB_EXEC: state_nxt = ARB_RESP;
      ARB_RESP: begin
        if (owner_rsp_ready) begin
          state_nxt = accept ? ARB_EXEC : ARB_IDLE;
        end
      end
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= PORT0;
      last     <= PORT1;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= win;
        last    <= win;
        alu_a   <= (win == PORT1) ? req1_a   : req0_a;
        alu_b   <= (win == PORT1) ? req1_b   : req0_b;
        alu_sel <= (win == PORT1) ? req1_sel : req0_sel;
      end
      if (state == ARB_EXEC) begin
        rsp_data <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with the real
// alu behind it. Inputs are driven on the falling edge, outputs checked 1 time
// unit later.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data, alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;

  int unsigned applied = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out)
  );

  alu #(.WIDTH(16), .SEL_W(4)) u_alu (
    .a(alu_a), .b(alu_b), .sel(alu_sel), .y(alu_out)
  );

  typedef struct {
    bit          port;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [15:0] alu_ref(input logic [15:0] a, b, input logic [3:0] s);
    logic signed [15:0] sa;
    sa = a;
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return a << b[3:0];
      4'd7:  return a >> b[3:0];
      4'd8:  return sa >>> b[3:0];
      4'd9:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd10: return (a < b) ? 16'd1 : 16'd0;
      4'd11: return a;
      4'd12: return b;
      4'd13: return ~a;
      4'd14: return a + 16'd1;
      default: return a - 16'd1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input logic v, input logic [15:0] a, b,
                         input logic [3:0] s);
    if (port == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
    end
  endtask

  task automatic quiet(input string tag, input logic [15:0] ea, eb, ed, input logic [3:0] es);
    chk({tag, " readies"}, {req0_ready, req1_ready}, 2'b00);
    chk({tag, " rsp valids"}, {rsp0_valid, rsp1_valid}, 2'b00);
    chk({tag, " alu pins"}, {alu_a, alu_b}, {ea, eb});
    chk({tag, " alu_sel"}, alu_sel, es);
    chk({tag, " rsp_data"}, rsp_data, ed);
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  // Entered just after a falling edge with the arbiter idle; returns the same way.
  task automatic run_op(input string tag, input bit port, input logic [15:0] a, b,
                        input logic [3:0] s, input logic [15:0] exp);
    set_req(port, 1'b1, a, b, s);
    set_req(~port, 1'b0, 16'h0, 16'h0, 4'h0);
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk({tag, " accept"}, {req0_ready, req1_ready}, port ? 2'b01 : 2'b10);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk({tag, " exec readies"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);
    chk({tag, " exec pins"}, {alu_a, alu_b, 12'h0, alu_sel}, {a, b, 12'h0, s});
    @(negedge clk);
    #1;
    chk({tag, " rsp valid"}, {rsp0_valid, rsp1_valid}, port ? 2'b01 : 2'b10);
    chk({tag, " rsp_data"}, rsp_data, exp);
    if (port) rsp1_ready = 1; else rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa, wb, we;
    logic [3:0]  ws;
    bit          wport, exp_port;
    int unsigned n0, n1, step;

    vecs[0]  = '{0, 16'h1234, 16'h5678, 4'd0,  16'h68AC};
    vecs[1]  = '{1, 16'h5678, 16'h1234, 4'd1,  16'h4444};
    vecs[2]  = '{0, 16'hF0F0, 16'hFF00, 4'd2,  16'hF000};
    vecs[3]  = '{1, 16'hF0F0, 16'h0F0F, 4'd3,  16'hFFFF};
    vecs[4]  = '{0, 16'hAAAA, 16'hFFFF, 4'd4,  16'h5555};
    vecs[5]  = '{1, 16'h00F0, 16'h0F00, 4'd5,  16'hF00F};
    vecs[6]  = '{0, 16'h0001, 16'h000F, 4'd6,  16'h8000};
    vecs[7]  = '{1, 16'h8000, 16'h0004, 4'd7,  16'h0800};
    vecs[8]  = '{0, 16'h8000, 16'h0004, 4'd8,  16'hF800};
    vecs[9]  = '{1, 16'hFFFF, 16'h0001, 4'd9,  16'h0001};
    vecs[10] = '{0, 16'hFFFF, 16'h0001, 4'd10, 16'h0000};
    vecs[11] = '{1, 16'hBEEF, 16'h1234, 4'd11, 16'hBEEF};
    vecs[12] = '{0, 16'hBEEF, 16'h1234, 4'd12, 16'h1234};
    vecs[13] = '{1, 16'h00FF, 16'h0000, 4'd13, 16'hFF00};
    vecs[14] = '{0, 16'hFFFF, 16'h0000, 4'd14, 16'h0000};
    vecs[15] = '{1, 16'h0000, 16'h0000, 4'd15, 16'hFFFF};
    vecs[16] = '{0, 16'hFFFF, 16'h0001, 4'd0,  16'h0000};

    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    quiet("reset", 16'h0, 16'h0, 16'h0, 4'h0);

    // Table of single transactions, alternating ports.
    for (int unsigned i = 0; i < 17; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b,
             vecs[i].sel, vecs[i].exp);
    end
    #1;
    chk("pins hold after op", {alu_a, alu_b, 12'h0, alu_sel}, {16'hFFFF, 16'h0001, 16'h0000});

    // Response stall on port 1 with port 0 knocking.
    set_req(1, 1, 16'hFFFF, 16'hFFFF, 4'd0);
    #1;
    chk("stall accept", {req0_ready, req1_ready}, 2'b01);
    @(negedge clk);
    req1_valid = 0;
    set_req(0, 1, 16'h0003, 16'h0004, 4'd0);
    #1;
    chk("stall exec readies", {req0_ready, req1_ready}, 2'b00);
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("stall rsp valids", {rsp0_valid, rsp1_valid}, 2'b01);
      chk("stall rsp_data", rsp_data, 16'hFFFE);
      chk("stall pins", {alu_a, alu_b, 12'h0, alu_sel}, {16'hFFFF, 16'hFFFF, 16'h0000});
      chk("stall readies", {req0_ready, req1_ready}, 2'b00);
    end
    // Release: response and next request accepted in the same cycle.
    @(negedge clk);
    rsp1_ready = 1;
    #1;
    chk("b2b accept p0", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    rsp1_ready = 0; req0_valid = 0;
    #1;
    chk("b2b exec pins", {alu_a, alu_b}, {16'h0003, 16'h0004});
    @(negedge clk);
    #1;
    chk("b2b rsp0", {rsp0_valid, rsp1_valid}, 2'b10);
    chk("b2b rsp0 data", rsp_data, 16'h0007);
    rsp0_ready = 1;
    set_req(1, 1, 16'h0010, 16'h0001, 4'd1);
    #1;
    chk("b2b accept p1 in RESP", {req0_ready, req1_ready}, 2'b01);
    @(negedge clk);
    rsp0_ready = 0; req1_valid = 0;
    #1;
    chk("b2b exec no valids", {rsp0_valid, rsp1_valid}, 2'b00);
    @(negedge clk);
    #1;
    chk("b2b rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
    chk("b2b rsp1 data", rsp_data, 16'h000F);
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;

    // Reset during EXEC.
    set_req(0, 1, 16'h1111, 16'h2222, 4'd0);
    #1;
    chk("rst-exec accept", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    do_reset();
    quiet("after rst in EXEC", 16'h0, 16'h0, 16'h0, 4'h0);
    set_req(0, 1, 16'h0101, 16'h0202, 4'd4);
    set_req(1, 1, 16'h0303, 16'h0404, 4'd4);
    #1;
    chk("first grant after rst-exec", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    #1;
    chk("post-rst op data", {rsp0_valid, rsp1_valid, 14'h0, rsp_data}, {2'b10, 14'h0, 16'h0303});
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;

    // Reset during RESP.
    run_op("pre rst-resp", 1, 16'h0005, 16'h0007, 4'd10, 16'h0001);
    set_req(1, 1, 16'h0009, 16'h0001, 4'd0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    #1;
    chk("rst-resp valid", {rsp0_valid, rsp1_valid}, 2'b01);
    do_reset();
    quiet("after rst in RESP", 16'h0, 16'h0, 16'h0, 4'h0);

    // Idle: nothing requested for 10 cycles.
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      quiet("idle", 16'h0, 16'h0, 16'h0, 4'h0);
    end

    // Both ports valid every cycle, response always accepted.
`ifdef ALU_ARB_RR_EN
    step = 2;
`else
    step = 1;
`endif
    n0 = 0; n1 = 0;
    @(negedge clk);
    set_req(0, 1, 16'h1000, 16'h0003, 4'd0);
    set_req(1, 1, 16'h2000, 16'h0005, 4'(step - 1));
    rsp0_ready = 1; rsp1_ready = 1;
    for (int unsigned k = 0; k < 16; k++) begin
      #1;
`ifdef ALU_ARB_RR_EN
      exp_port = k[0];
`else
      exp_port = 1'b0;
`endif
      chk($sformatf("arb grant %0d", k), {req0_ready, req1_ready}, exp_port ? 2'b01 : 2'b10);
      wport = req1_ready;
      wa = wport ? req1_a : req0_a;
      wb = wport ? req1_b : req0_b;
      ws = wport ? req1_sel : req0_sel;
      we = alu_ref(wa, wb, ws);
      @(negedge clk);
      if (wport) begin
        n1++;
        set_req(1, 1, 16'h2000 + 16'(n1), 16'h0005, 4'(n1 * step + step - 1));
      end else begin
        n0++;
        set_req(0, 1, 16'h1000 + 16'(n0), 16'h0003, 4'(n0 * step));
      end
      if (k == 15) begin
        req0_valid = 0; req1_valid = 0;
      end
      #1;
      chk("arb exec readies", {req0_ready, req1_ready}, 2'b00);
      chk("arb exec pins", {alu_a, alu_b, 12'h0, alu_sel}, {wa, wb, 12'h0, ws});
      @(negedge clk);
      #1;
      chk("arb rsp valid", {rsp0_valid, rsp1_valid}, wport ? 2'b01 : 2'b10);
      chk("arb rsp data", rsp_data, we);
    end
`ifndef ALU_ARB_RR_EN
    chk("fixed: port1 never granted", n1, 0);
`endif
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("arb end idle", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 16-bit `alu` between two requesters (port 0: execute stage, port 1: auxiliary/address unit) with valid/ready handshakes on both request and response sides. Accepted operands are registered and driven onto the ALU pins; the ALU result is captured and held until the owning requester accepts it. Sits between the requesters and the `alu` instance; one operation is in flight at a time.

## Interface
- `WIDTH`, 16, operand/result width
- `SEL_W`, 4, ALU operation select width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / 1
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (valid & ready)
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_sel` / `req1_sel`  in  SEL_W  ALU operation
- `rsp0_valid` / `rsp1_valid`  out  1  result available for port 0 / 1
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes result
- `rsp_data`  out  WIDTH  held result (shared; qualified by `rspN_valid`)
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU
- `alu_sel`  out  SEL_W  registered select to ALU
- `alu_out`  in  WIDTH  ALU combinational result

## Operation
- States: IDLE, EXEC, RESP. Registers: `state`, `owner` (1 bit), `last` (1 bit), operand regs, result reg.
- IDLE: `can_accept`=1. Winner chosen among valid ports; `req<win>_ready`=1, other ready=0. On handshake: operands/sel latched into `alu_a/alu_b/alu_sel`, `owner`<=win, `last`<=win, -> EXEC. No valid: stay IDLE.
- EXEC: `rsp_data`<=`alu_out`, -> RESP. No readies asserted.
- RESP: `rsp<owner>_valid`=1, other rsp_valid=0. `rsp<owner>_ready`=0: hold, `rsp_data`/ALU pins stable. `rsp<owner>_ready`=1: `can_accept`=1 same cycle; if a request handshakes -> EXEC with new operands, else -> IDLE.
- Ready never depends on the non-winning port's ready/valid except through arbitration; `reqN_ready` may be combinational on `reqN_valid`.
- `rsp_data` is plain WIDTH capture of `alu_out`; no arithmetic inside the arbiter, no width extension.
- Requester must hold request fields stable while valid & !ready.
- Reset values: state=IDLE, `owner`=0, `last`=1, `alu_a`=`alu_b`=0, `alu_sel`=0, `rsp_data`=0, all ready/valid outputs 0 in the cycle after reset is sampled.
- Reset mid-operation (EXEC or RESP): in-flight result discarded, no response delivered; requester reissues.

## Timing
- Handshake at edge N (IDLE) -> EXEC in cycle N+1 -> `rspN_valid`=1 from cycle N+2.
- Minimum latency 2 cycles request-accept to response-valid.
- Back-to-back: response accepted and next request accepted in the same RESP cycle; peak throughput 1 op per 2 cycles.
- `alu_*` pins change only on the accept edge; stable through EXEC and RESP.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin; with both valid, winner = !`last`; single valid always wins.
- Not defined: fixed priority, port 0 wins whenever `req0_valid`=1; `last` still tracked but unused.

## Structure
- Package `alu_arb_pkg`: state enum (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`), `WIDTH`/`SEL_W` defaults, port-index constants.
- Sub-module `alu_arb_pick`: combinational 2-way picker (inputs: valids, `last`, enable; output: win, any); macro selects RR vs fixed inside it.
- Bench instantiates the real `alu` behind the arbiter; expected data = ALU output for the same a/b/sel applied directly.

## Test plan
- Reset then port 0 only, a=16'h1234, b=16'h5678, sel=0 -> `req0_ready` cycle 0, `rsp0_valid` cycle 2, `rsp_data` = direct-ALU result; `rsp1_valid` stays 0.
- Both valid every cycle, all sel 0..15, `rspN_ready`=1, RR build -> grants alternate 0,1,0,1 starting port 0; fixed build -> port 1 never granted.
- Response stall: port 1 a=16'hffff, b=16'hffff, `rsp1_ready` low 5 cycles -> `rsp1_valid`/`rsp_data`/`alu_*` stable, both reqN_ready=0 throughout.
- Back-to-back: `rsp0_ready`=1 and `req1_valid`=1 in RESP -> `req1_ready`=1 same cycle, `rsp1_valid` two cycles later, no IDLE cycle.
- `rst` asserted during EXEC and during RESP -> next cycle all valid/ready 0, `alu_*`=0, first grant afterwards goes to port 0.
- Idle: no valids 10 cycles -> all outputs at reset values, `alu_*` unchanged.
